// File: rtl/fifo_pkg.sv
// Shared constants for the parameterised FIFO and its storage.
package fifo_pkg;

  // Default data word width in bits.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Default number of entries; must be a power of two.
  localparam int unsigned DEFAULT_DEPTH = 16;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port and one registered read port.
// The array itself is never reset; only the read-data register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Storage write; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data loads only on an accepted read, otherwise it holds.
  // A same-edge write to raddr_i is not visible here: the old word is returned.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Read-data register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO: pointers, occupancy count, status flags and
// overflow/underflow pulses. Storage and the read-data register live in fifo_mem.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfCnt    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeCnt    = CntW'(AE_LEVEL);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1) begin : gen_bad_width
    $error("param_fifo: WIDTH must be at least 1");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("param_fifo: DEPTH must be a power of two and at least 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : gen_bad_levels
    $error("param_fifo: AE_LEVEL must be below AF_LEVEL");
  end
  if (AF_LEVEL > DEPTH) begin : gen_bad_af
    $error("param_fifo: AF_LEVEL must not exceed DEPTH");
  end

  logic [AddrW-1:0] wptr_d, wptr_q;
  logic [AddrW-1:0] rptr_d, rptr_q;
  logic [CntW-1:0]  count_d, count_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic             wr_ok;
  logic             rd_ok;

  // Flags come from the registered count only, so they settle one edge after the cause.
  always_comb begin
    full         = (count_q == DepthCnt);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfCnt);
    almost_empty = (count_q <= AeCnt);
  end

  // Accept decisions and next-state for pointers, count and error pulses.
  // A read is judged first so that a full FIFO can still take a write in the
  // same cycle as an accepted read. clr overrides everything and raises no pulse.
  always_comb begin
    rd_ok       = rd & ~empty & ~clr;
    wr_ok       = wr & (~full | rd_ok) & ~clr;
    overflow_d  = wr & ~wr_ok & ~clr;
    underflow_d = rd & ~rd_ok & ~clr;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) begin
        wptr_d = wptr_q + AddrW'(1);
      end
      if (rd_ok) begin
        rptr_d = rptr_q + AddrW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous reset; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (din),
    .re_i    (rd_ok),
    .raddr_i (rptr_q),
    .rdata_o (dout)
  );

endmodule
